// File: rtl/aes_pkg.sv
// AES shared definitions: S-box tables, Rcon, GF(2^8) helpers, FSM states.
// Also used by the Encrypt block.
package aes_pkg;

    localparam int NR = 14;

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND,
        DONE
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Index is round-key number / 2 for the even AES-256 expansion steps.
    localparam logic [0:7][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // One inverse round on a column-major state (byte n = bits [127-8n -: 8]).
    function automatic logic [127:0] inv_round(
        input logic [127:0] s,
        input logic [127:0] rk,
        input logic         mix
    );
        logic [0:15][7:0] a;
        logic [0:15][7:0] b;
        logic [0:15][7:0] m;
        a = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = INV_SBOX[a[4*((c-r+4)%4)+r]];
        b = b ^ rk;
        m = b;
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                m[4*c]   = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b)
                         ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
                m[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e)
                         ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
                m[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09)
                         ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
                m[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d)
                         ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/aes256_key_step.sv
// AES-256 key expansion step: round key i from round keys i-2 and i-1.
// Even i uses RotWord+SubWord+Rcon, odd i uses SubWord only.
module aes256_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_prev2,
    input  logic [127:0] i_prev1,
    input  logic [3:0]   i_idx,
    output logic [127:0] o_next
);

    logic [31:0] w_last;
    logic [31:0] w_temp;
    logic [31:0] w_0;
    logic [31:0] w_1;
    logic [31:0] w_2;
    logic [31:0] w_3;

    assign w_last = i_prev1[31:0];

    always_comb begin
        w_temp = sub_word(w_last);
        if (!i_idx[0])
            w_temp = sub_word({w_last[23:0], w_last[31:24]})
                   ^ {RCON[i_idx[3:1]], 24'h000000};
    end

    assign w_0 = i_prev2[127:96] ^ w_temp;
    assign w_1 = i_prev2[95:64]  ^ w_0;
    assign w_2 = i_prev2[63:32]  ^ w_1;
    assign w_3 = i_prev2[31:0]   ^ w_2;

    assign o_next = {w_0, w_1, w_2, w_3};

endmodule

// File: rtl/aes256_decrypt.sv
// Iterative AES-256 inverse cipher, one round per cycle, with a
// single-entry key cache that skips key expansion on a repeated key.
module aes256_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [255:0] key,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [3:0] LAST = 4'(NR);

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic         r_cache_valid;
    logic [255:0] r_key;
    logic [127:0] r_ct;
    logic [127:0] r_st;
    logic [127:0] r_out;
    logic [127:0] r_rk [0:NR];

    logic         w_accept;
    logic         w_hit;
    logic [127:0] w_prev2;
    logic [127:0] w_prev1;
    logic [127:0] w_rk_next;
    logic [127:0] w_round;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;

    assign w_accept = in_valid && in_ready;
    assign w_hit    = r_cache_valid && (key == r_key);

    assign w_prev2 = r_rk[r_cnt - 4'd2];
    assign w_prev1 = r_rk[r_cnt - 4'd1];
    assign w_round = inv_round(r_st, r_rk[r_cnt], r_cnt != 4'd0);

    aes256_key_step u_key_step (
        .i_prev2 (w_prev2),
        .i_prev1 (w_prev1),
        .i_idx   (r_cnt),
        .o_next  (w_rk_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_hit ? ROUND : KEYEXP;
            KEYEXP:  if (r_cnt == LAST) w_next = ROUND;
            ROUND:   if (r_cnt == 4'd0) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= 4'd0;
            r_cache_valid <= 1'b0;
            r_st          <= '0;
            r_out         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_st  <= in ^ r_rk[NR];
                            r_cnt <= LAST - 4'd1;
                        end else begin
                            r_cache_valid <= 1'b0;
                            r_cnt         <= 4'd2;
                        end
                    end
                end
                KEYEXP: begin
                    // Last step feeds the fresh rk14 straight into the state.
                    if (r_cnt == LAST) begin
                        r_cache_valid <= 1'b1;
                        r_st          <= r_ct ^ w_rk_next;
                        r_cnt         <= LAST - 4'd1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ROUND: begin
                    if (r_cnt == 4'd0) begin
                        r_out <= w_round;
                    end else begin
                        r_st  <= w_round;
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key material is only trusted while r_cache_valid is set.
    always_ff @(posedge clk) begin
        if (w_accept && !w_hit) begin
            r_key   <= key;
            r_ct    <= in;
            r_rk[0] <= key[255:128];
            r_rk[1] <= key[127:0];
        end
        if (r_state == KEYEXP)
            r_rk[r_cnt] <= w_rk_next;
    end

endmodule
